ascii_uart_tx: RTL and testbench
================================

# ascii_uart_tx

Serial transmitter that consumes the 7-bit ASCII characters produced by the hex-to-ASCII converter and drives them onto a single UART-style line. Each accepted character becomes one asynchronous frame: a start bit, 7 data bits LSB first, an optional even-parity bit and one stop bit. A valid/ready handshake lets any upstream source stall until the line is free. Together with the hex-to-ASCII converter, this gives the design a hex-digit-to-serial-text path for terminal output.

## Interface

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range is 2 or more.
- PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- A  input  7  ASCII character from the converter; sampled only on an accept edge.
- a_valid  input  1  A holds a character to send.
- a_ready  output  1  block can accept a character; equals (state==IDLE) && !rst.
- tx  output  1  serial line, registered; idle level is 1.
- busy  output  1  registered; 1 whenever state != IDLE.

## Operation

- States:
  - IDLE: tx=1. On a_valid && a_ready, latch A into shift register sh[6:0], compute par = ^A, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=sh[idx] for CLKS_PER_BIT cycles per bit, idx 0..6. After idx 6, go to PARITY if PARITY_EN=1, otherwise go to STOP.
  - PARITY: tx=par for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Counters:
  - Cycle counter runs 0..CLKS_PER_BIT-1 and wraps to 0 on each bit change.
  - 3-bit bit index counts data bits.
  - Both counters are cleared on entry to START.
- Parity is even: the parity bit makes the total count of 1s over the 7 data bits plus the parity bit even.
- A and a_valid are ignored outside IDLE. Changes to A mid-frame do not affect the frame in flight.
- If a_valid is low in IDLE, the block stays in IDLE with tx=1 indefinitely.
- Reset has priority over every other event, including an accept in the same cycle. On the reset edge:
  - state=IDLE, tx=1, busy=0;
  - counters and sh are cleared;
  - an in-flight frame is abandoned with no stop bit emitted.

## Timing

- Reset values: tx=1, busy=0, a_ready=0 while rst=1. a_ready=1 in the first cycle after rst deasserts.
- Frame length F = (9 + PARITY_EN) * CLKS_PER_BIT cycles.
- Accept at edge k: tx=0 and busy=1 from cycle k+1, i.e. 1 cycle latency from accept to the start bit.
- Bit n of the frame (start = bit 0) is driven during cycles k+1+n*CLKS_PER_BIT through k+(n+1)*CLKS_PER_BIT.
- The last stop-bit cycle is k+F. State is IDLE at k+F+1, so a_ready=1 and busy=0 in that cycle.
- Back-to-back with a_valid held high: accept edges are spaced exactly F+1 cycles apart, with one idle cycle of tx=1 between frames.
- a_ready is combinational from state and rst. a_valid may depend combinationally on a_ready without forming a loop inside this block.

## Test plan

- Reset:
  - Stimulus: rst=1 for 3 cycles with a_valid=1, A=0x41.
  - Required: tx=1, busy=0, a_ready=0 throughout reset, and no frame starts on the reset edges.
  - Required: after rst=0, a_ready=1 and the pending 'A' is accepted on the next edge.
- Single character 'A' (0x41), CLKS_PER_BIT=16, PARITY_EN=1:
  - Required tx bit sequence: 0, 1,0,0,0,0,0,1, 0 (parity), 1, each bit held 16 cycles.
  - Required: busy=1 for 160 cycles, then a_ready=1.
- Odd-weight character '7' (0x37):
  - Required data bits 1,1,1,0,1,1,0, then parity=1, then stop=1.
  - Same test with PARITY_EN=0: frame is 144 cycles and the stop bit follows the data bits directly.
- Stream from the hex-to-ASCII converter with a_valid held high:
  - Stimulus: feed hex digits 0..F.
  - Required: accepts spaced 161 cycles apart.
  - Required: a bench-side UART decoder recovers 0x30..0x39 then 0x41..0x46 with zero parity errors.
- Input stability:
  - Stimulus: change A from 0x41 to 0x46 during DATA.
  - Required: the frame still carries 0x41; 0x46 is sent only if presented again when a_ready=1.
- Reset mid-frame:
  - Stimulus: assert rst for 1 cycle at data bit 3.
  - Required: in the next cycle tx=1, busy=0, a_ready=1.
  - Required: the next accepted character (0x42) produces a complete, correct frame.

Source files
------------

// File: rtl/ascii_uart_tx_if.sv
// Character handshake between an ASCII source (e.g. the hex-to-ASCII converter)
// and the UART transmitter.
interface ascii_uart_tx_if;
  logic [6:0] A;
  logic       a_valid;
  logic       a_ready;

  modport master (
    output A,
    output a_valid,
    input  a_ready
  );

  modport slave (
    input  A,
    input  a_valid,
    output a_ready
  );
endinterface

// File: rtl/ascii_uart_tx.sv
// UART-style transmitter for 7-bit ASCII: start bit, 7 data bits LSB first,
// optional even parity, one stop bit. Registered tx/busy, valid/ready input.
module ascii_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ascii_uart_tx_if.slave a_if,
  output logic           tx,
  output logic           busy
);

  localparam int unsigned         CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]          IDX_LAST = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       idx_q,   idx_d;
  logic [6:0]       sh_q,    sh_d;
  logic             par_q,   par_d;
  logic             tx_q,    tx_d;
  logic             busy_q,  busy_d;

  logic             accept;
  logic             bit_done;

  // a_ready depends only on state and rst, so an upstream a_valid may be
  // derived from it without closing a combinational loop here.
  assign a_if.a_ready = (state_q == S_IDLE) && !rst;
  assign accept       = a_if.a_valid && a_if.a_ready;
  assign bit_done     = (cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift register and parity latch are cleared as well; they
      // are ordinary flops, and a clean value keeps a reset mid-frame tidy.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    par_d   = par_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = a_if.A;
          par_d   = ^a_if.A;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = PARITY_EN ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PARITY: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: decoded from the next state so tx/busy are registered yet
  // change on the same edge as the state, giving one cycle accept-to-start.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);

    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[idx_d];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Directed bench for ascii_uart_tx: reset, single frames with/without parity,
// input stability, reset mid-frame and a hex-digit stream with a UART decoder.
module tb_ascii_uart_tx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_p, busy_p, tx_n, busy_n;

  ascii_uart_tx_if if_p ();
  ascii_uart_tx_if if_n ();

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    .clk  (clk),
    .rst  (rst),
    .a_if (if_p),
    .tx   (tx_p),
    .busy (busy_p)
  );

  ascii_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_n (
    .clk  (clk),
    .rst  (rst),
    .a_if (if_n),
    .tx   (tx_n),
    .busy (busy_n)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input bit n);
    return n ? tx_n : tx_p;
  endfunction

  function automatic logic get_busy(input bit n);
    return n ? busy_n : busy_p;
  endfunction

  function automatic logic get_ready(input bit n);
    return n ? if_n.a_ready : if_p.a_ready;
  endfunction

  task automatic drive(input bit n, input logic [6:0] ch, input logic v);
    if (n) begin
      if_n.A       = ch;
      if_n.a_valid = v;
    end else begin
      if_p.A       = ch;
      if_p.a_valid = v;
    end
  endtask

  // Bench-side hex-to-ASCII converter.
  function automatic logic [6:0] hex2asc(input int d);
    return (d < 10) ? 7'(7'h30 + d) : 7'(7'h41 + (d - 10));
  endfunction

  // Frame bit n (start = bit 0) for a parity-enabled frame.
  function automatic logic [9:0] frame_bits(input logic [6:0] ch);
    logic [9:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) f[i+1] = ch[i];
    f[8] = ^ch;
    f[9] = 1'b1;
    return f;
  endfunction

  // Waits (bounded) for a_ready, then lets the accept edge happen.
  task automatic wait_accept(input bit n, output int unsigned at);
    bit got;
    got = 1'b0;
    at  = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (get_ready(n)) begin
        tick();
        at  = cyc;
        got = 1'b1;
      end else begin
        tick();
      end
    end
    check("accept_within_bound", 32'(got), 32'd1);
  endtask

  // Called in the first cycle after the accept edge. Checks every cycle of
  // each bit, decodes mid-bit samples, then checks the idle cycle that follows.
  task automatic run_frame(input bit n, input string tag, input int nbits,
                           input logic [9:0] exp, input int chg_at,
                           input logic [6:0] chg_ch,
                           output logic [6:0] dec, output bit par_ok);
    logic [15:0] s;
    logic [9:0]  mid;
    int          busy_cnt;
    mid      = '0;
    busy_cnt = 0;
    for (int b = 0; b < nbits; b++) begin
      s = '0;
      for (int c = 0; c < CPB; c++) begin
        if (b * CPB + c == chg_at) drive(n, chg_ch, 1'b1);
        s[c] = get_tx(n);
        if (c == CPB / 2) mid[b] = s[c];
        if (get_busy(n)) busy_cnt++;
        tick();
      end
      check($sformatf("%s bit%0d", tag, b), 32'(s), exp[b] ? 32'h0000_FFFF : 32'h0);
    end
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(nbits * CPB));
    check({tag, " idle_busy"},  32'(get_busy(n)),  32'd0);
    check({tag, " idle_ready"}, 32'(get_ready(n)), 32'd1);
    check({tag, " idle_tx"},    32'(get_tx(n)),    32'd1);
    dec    = mid[7:1];
    par_ok = (nbits == 10) ? ~(^mid[8:1]) : 1'b1;
  endtask

  initial begin
    int unsigned t, prev, rel;
    logic [6:0]  dec;
    bit          pok;
    int          par_errs;

    // ---- Reset with a pending 'A' ----
    drive(1'b0, 7'h41, 1'b1);
    drive(1'b1, 7'h00, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset tx",    32'(tx_p),       32'd1);
      check("reset busy",  32'(busy_p),     32'd0);
      check("reset ready", 32'(if_p.a_ready), 32'd0);
    end
    rel = cyc;
    rst = 1'b0;
    #1;
    check("post-reset ready", 32'(if_p.a_ready), 32'd1);
    check("post-reset busy",  32'(busy_p),       32'd0);
    check("post-reset tx",    32'(tx_p),         32'd1);
    wait_accept(1'b0, t);
    check("accept on first edge after reset", t - rel, 32'd1);
    drive(1'b0, 7'h41, 1'b0);
    run_frame(1'b0, "A", 10, 10'b1010000010, -1, 7'h00, dec, pok);
    check("A decoded", 32'(dec), 32'h41);
    check("A parity",  32'(pok), 32'd1);

    // ---- Odd-weight '7', parity enabled ----
    drive(1'b0, 7'h37, 1'b1);
    wait_accept(1'b0, t);
    drive(1'b0, 7'h37, 1'b0);
    run_frame(1'b0, "7p", 10, 10'b1101101110, -1, 7'h00, dec, pok);
    check("7p decoded", 32'(dec), 32'h37);
    check("7p parity",  32'(pok), 32'd1);

    // ---- '7', parity disabled: stop follows data directly ----
    drive(1'b1, 7'h37, 1'b1);
    wait_accept(1'b1, t);
    drive(1'b1, 7'h37, 1'b0);
    run_frame(1'b1, "7n", 9, 10'b0101101110, -1, 7'h00, dec, pok);
    check("7n decoded", 32'(dec), 32'h37);

    // ---- Input stability: A changes to 'F' during data bit 1 ----
    drive(1'b0, 7'h41, 1'b1);
    wait_accept(1'b0, t);
    drive(1'b0, 7'h41, 1'b0);
    run_frame(1'b0, "stab", 10, 10'b1010000010, 2 * CPB + 3, 7'h46, dec, pok);
    check("stab decoded", 32'(dec), 32'h41);
    wait_accept(1'b0, t);
    drive(1'b0, 7'h46, 1'b0);
    run_frame(1'b0, "F", 10, frame_bits(7'h46), -1, 7'h00, dec, pok);
    check("F decoded", 32'(dec), 32'h46);

    // ---- Reset mid-frame at data bit 3, then a clean 'B' ----
    drive(1'b0, 7'h41, 1'b1);
    wait_accept(1'b0, t);
    drive(1'b0, 7'h41, 1'b0);
    repeat (4 * CPB + CPB / 2) tick();
    check("mid tx before reset",   32'(tx_p),   32'd0);
    check("mid busy before reset", 32'(busy_p), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("after mid reset tx",    32'(tx_p),         32'd1);
    check("after mid reset busy",  32'(busy_p),       32'd0);
    check("after mid reset ready", 32'(if_p.a_ready), 32'd1);
    drive(1'b0, 7'h42, 1'b1);
    wait_accept(1'b0, t);
    drive(1'b0, 7'h42, 1'b0);
    run_frame(1'b0, "B", 10, 10'b1010000100, -1, 7'h00, dec, pok);
    check("B decoded", 32'(dec), 32'h42);
    check("B parity",  32'(pok), 32'd1);

    // ---- Hex digit stream 0..F with a_valid held high ----
    par_errs = 0;
    prev     = 0;
    for (int d = 0; d < 16; d++) begin
      drive(1'b0, hex2asc(d), 1'b1);
      wait_accept(1'b0, t);
      if (d > 0) check($sformatf("stream spacing %0d", d), t - prev, 32'd161);
      prev = t;
      run_frame(1'b0, $sformatf("stream%0d", d), 10, frame_bits(hex2asc(d)), -1, 7'h00, dec, pok);
      check($sformatf("stream char %0d", d), 32'(dec), 32'(hex2asc(d)));
      if (!pok) par_errs++;
    end
    drive(1'b0, 7'h00, 1'b0);
    check("stream parity errors", 32'(par_errs), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
